// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-write scoreboard in front of the 32-entry integer register file.
// Define REGFILE_WB_BYPASS_EN to add output-stage forwarding to both decode read ports.

module regfile_wb_hazard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic [ADDR_WIDTH-1:0]      rs,
    input  logic [2**ADDR_WIDTH-1:0]   busy_vec,
    input  logic                       stage_we,
    input  logic [ADDR_WIDTH-1:0]      stage_rd,
`ifdef REGFILE_WB_BYPASS_EN
    input  logic [DATA_WIDTH-1:0]      stage_data,
    output logic                       fwd,
    output logic [DATA_WIDTH-1:0]      fwd_data,
`endif
    output logic                       busy
);
    logic stage_hit;

    // The output stage holds a value the register file does not have yet.
    assign stage_hit = stage_we && (stage_rd == rs) && (rs != '0);

`ifdef REGFILE_WB_BYPASS_EN
    assign busy     = busy_vec[rs];
    assign fwd      = stage_hit;
    assign fwd_data = stage_data;
`else
    assign busy     = busy_vec[rs] | stage_hit;
`endif
endmodule

module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  logic [ADDR_WIDTH-1:0] req0_rd_i,
    input  logic [DATA_WIDTH-1:0] req0_data_i,
    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  logic [ADDR_WIDTH-1:0] req1_rd_i,
    input  logic [DATA_WIDTH-1:0] req1_data_i,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_rd_i,
    input  logic [ADDR_WIDTH-1:0] rs1_i,
    input  logic [ADDR_WIDTH-1:0] rs2_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
`ifdef REGFILE_WB_BYPASS_EN
    output logic                  rs1_fwd_o,
    output logic [DATA_WIDTH-1:0] rs1_fwd_data_o,
    output logic                  rs2_fwd_o,
    output logic [DATA_WIDTH-1:0] rs2_fwd_data_o,
`endif
    output logic                  issue_conflict_o,
    output logic                  Reg_Write_o,
    output logic [ADDR_WIDTH-1:0] Write_Register_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o
);
    localparam int NREG = 2**ADDR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wb_req_t;

    wb_req_t         req0, req1, win;
    logic            rr_req1;
    logic            grant0, grant1, contested, hs;
    logic [NREG-1:0] busy, busy_next;
    logic            issue_set, same_rd_clear, conflict;

    assign req0 = {req0_rd_i, req0_data_i};
    assign req1 = {req1_rd_i, req1_data_i};

    // rr_req1 = 1 means req1 wins the next contested cycle.
    assign contested    = req0_valid_i && req1_valid_i;
    assign grant0       = req0_valid_i && (!req1_valid_i || !rr_req1);
    assign grant1       = req1_valid_i && (!req0_valid_i ||  rr_req1);
    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign hs           = grant0 || grant1;
    assign win          = grant1 ? req1 : req0;

    assign issue_set     = issue_valid_i && (issue_rd_i != '0);
    assign same_rd_clear = grant1 && (req1_rd_i == issue_rd_i);
    assign conflict      = issue_set && busy[issue_rd_i] && !same_rd_clear;

    // Clear before set so a same-cycle issue to the retiring rd keeps the bit.
    always_comb begin
        busy_next = busy;
        if (grant1)
            busy_next[req1_rd_i] = 1'b0;
        if (issue_set)
            busy_next[issue_rd_i] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_req1          <= 1'b0;
            busy             <= '0;
            issue_conflict_o <= 1'b0;
        end else begin
            if (contested)
                rr_req1 <= grant0;
            busy <= busy_next;
            if (conflict)
                issue_conflict_o <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else if (hs) begin
            Reg_Write_o      <= (win.rd != '0);
            Write_Register_o <= win.rd;
            Write_Data_o     <= win.data;
        end else begin
            Reg_Write_o      <= 1'b0;
        end
    end

    logic [1:0][ADDR_WIDTH-1:0] rs_vec;
    logic [1:0]                 rs_busy;
`ifdef REGFILE_WB_BYPASS_EN
    logic [1:0]                 rs_fwd;
    logic [1:0][DATA_WIDTH-1:0] rs_fwd_data;
`endif

    assign rs_vec = {rs2_i, rs1_i};

    for (genvar g = 0; g < 2; g++) begin : g_rd
        regfile_wb_hazard #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_haz (
            .rs        (rs_vec[g]),
            .busy_vec  (busy),
            .stage_we  (Reg_Write_o),
            .stage_rd  (Write_Register_o),
`ifdef REGFILE_WB_BYPASS_EN
            .stage_data(Write_Data_o),
            .fwd       (rs_fwd[g]),
            .fwd_data  (rs_fwd_data[g]),
`endif
            .busy      (rs_busy[g])
        );
    end

    assign rs1_busy_o = rs_busy[0];
    assign rs2_busy_o = rs_busy[1];
`ifdef REGFILE_WB_BYPASS_EN
    assign rs1_fwd_o      = rs_fwd[0];
    assign rs2_fwd_o      = rs_fwd[1];
    assign rs1_fwd_data_o = rs_fwd_data[0];
    assign rs2_fwd_data_o = rs_fwd_data[1];
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors with literal checks plus a per-cycle model compare.
// Builds with or without REGFILE_WB_BYPASS_EN.

module tb_regfile_wb_arbiter;
    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 32;
`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req0_valid_i = 0, req1_valid_i = 0, issue_valid_i = 0;
    logic [AW-1:0] req0_rd_i = 0, req1_rd_i = 0, issue_rd_i = 0, rs1_i = 0, rs2_i = 0;
    logic [DW-1:0] req0_data_i = 0, req1_data_i = 0;
    logic          req0_ready_o, req1_ready_o, rs1_busy_o, rs2_busy_o, issue_conflict_o, Reg_Write_o;
    logic [AW-1:0] Write_Register_o;
    logic [DW-1:0] Write_Data_o;
`ifdef REGFILE_WB_BYPASS_EN
    logic          rs1_fwd_o, rs2_fwd_o;
    logic [DW-1:0] rs1_fwd_data_o, rs2_fwd_data_o;
`endif

    regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_rd_i(req0_rd_i), .req0_data_i(req0_data_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_rd_i(req1_rd_i), .req1_data_i(req1_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
        .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
`ifdef REGFILE_WB_BYPASS_EN
        .rs1_fwd_o(rs1_fwd_o), .rs1_fwd_data_o(rs1_fwd_data_o),
        .rs2_fwd_o(rs2_fwd_o), .rs2_fwd_data_o(rs2_fwd_data_o),
`endif
        .issue_conflict_o(issue_conflict_o), .Reg_Write_o(Reg_Write_o),
        .Write_Register_o(Write_Register_o), .Write_Data_o(Write_Data_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: who is owed the next contested grant, which registers await a
    // multi-cycle result, and what the write stage currently presents.
    logic            m_owed_req1;
    logic [NREG-1:0] m_pending;
    logic            m_we;
    logic [AW-1:0]   m_wr;
    logic [DW-1:0]   m_wd;
    logic            m_conf;
    logic            e_g0, e_g1;

    assign e_g0 = req0_valid_i && !(req1_valid_i && m_owed_req1);
    assign e_g1 = req1_valid_i && !e_g0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_owed_req1 <= 1'b0;
            m_pending   <= '0;
            m_we        <= 1'b0;
            m_wr        <= '0;
            m_wd        <= '0;
            m_conf      <= 1'b0;
        end else begin
            if (req0_valid_i && req1_valid_i)
                m_owed_req1 <= e_g0;
            if (e_g0) begin
                m_we <= (req0_rd_i != 0); m_wr <= req0_rd_i; m_wd <= req0_data_i;
            end else if (e_g1) begin
                m_we <= (req1_rd_i != 0); m_wr <= req1_rd_i; m_wd <= req1_data_i;
            end else begin
                m_we <= 1'b0;
            end
            if (issue_valid_i && issue_rd_i != 0 && m_pending[issue_rd_i]
                && !(e_g1 && req1_rd_i == issue_rd_i))
                m_conf <= 1'b1;
            if (e_g1)
                m_pending[req1_rd_i] <= 1'b0;
            if (issue_valid_i && issue_rd_i != 0)
                m_pending[issue_rd_i] <= 1'b1;
        end
    end

    function automatic logic stage_hit(input logic [AW-1:0] rs);
        return m_we && (m_wr == rs) && (rs != 0);
    endfunction

    function automatic logic exp_busy(input logic [AW-1:0] rs);
        return (rs != 0 && m_pending[rs]) || (!BYP && stage_hit(rs));
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            check("req0_ready", req0_ready_o, e_g0);
            check("req1_ready", req1_ready_o, e_g1);
            check("reg_write",  Reg_Write_o, m_we);
            if (m_we) begin
                check("write_reg",  Write_Register_o, m_wr);
                check("write_data", Write_Data_o, m_wd);
            end
            check("rs1_busy", rs1_busy_o, exp_busy(rs1_i));
            check("rs2_busy", rs2_busy_o, exp_busy(rs2_i));
            check("conflict", issue_conflict_o, m_conf);
`ifdef REGFILE_WB_BYPASS_EN
            check("rs1_fwd", rs1_fwd_o, stage_hit(rs1_i));
            check("rs2_fwd", rs2_fwd_o, stage_hit(rs2_i));
            if (stage_hit(rs1_i)) check("rs1_fwd_data", rs1_fwd_data_o, m_wd);
            if (stage_hit(rs2_i)) check("rs2_fwd_data", rs2_fwd_data_o, m_wd);
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0_valid_i = 0; req1_valid_i = 0; issue_valid_i = 0;
    endtask

    int exp_seq[4] = '{1, 2, 1, 2};
    bit hold0, hold1;

    initial begin
        rs1_i = 5; rs2_i = 31;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_reg_write", Reg_Write_o, 0);
        check("rst_write_reg", Write_Register_o, 0);
        check("rst_write_data", Write_Data_o, 0);
        check("rst_rs1_busy", rs1_busy_o, 0);
        check("rst_rs2_busy", rs2_busy_o, 0);
        check("rst_conflict", issue_conflict_o, 0);
        next_cycle();

        // Single req0 write
        req0_valid_i = 1; req0_rd_i = 7; req0_data_i = 32'hDEADBEEF;
        @(negedge clk);
        check("r0_ready", req0_ready_o, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("r0_reg_write", Reg_Write_o, 1);
        check("r0_write_reg", Write_Register_o, 7);
        check("r0_write_data", Write_Data_o, 32'hDEADBEEF);
        next_cycle();

        // Contested: grants alternate starting with req0
        req0_valid_i = 1; req0_rd_i = 1; req0_data_i = 32'h11111111;
        req1_valid_i = 1; req1_rd_i = 2; req1_data_i = 32'h22222222;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_ready0", req0_ready_o, (i % 2) == 0);
            check("rr_ready1", req1_ready_o, (i % 2) == 1);
            if (i > 0) check("rr_write_reg", Write_Register_o, exp_seq[i-1]);
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("rr_write_reg_last", Write_Register_o, exp_seq[3]);
        check("rr_write_data_last", Write_Data_o, 32'h22222222);
        next_cycle();

        // Hazard on rd=9 until its req1 write retires
        issue_valid_i = 1; issue_rd_i = 9; rs1_i = 9; rs2_i = 0;
        @(negedge clk);
        check("haz_same_cycle", rs1_busy_o, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("haz_busy1", rs1_busy_o, 1);
        check("haz_rs2_zero", rs2_busy_o, 0);
        next_cycle();
        @(negedge clk);
        check("haz_busy2", rs1_busy_o, 1);
        next_cycle();
        req1_valid_i = 1; req1_rd_i = 9; req1_data_i = 32'h00000099;
        @(negedge clk);
        check("haz_r1_ready", req1_ready_o, 1);
        check("haz_busy3", rs1_busy_o, 1);
        next_cycle();
        idle();
        @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
        check("haz_stage_busy", rs1_busy_o, 0);
        check("haz_fwd", rs1_fwd_o, 1);
        check("haz_fwd_data", rs1_fwd_data_o, 32'h00000099);
`else
        check("haz_stage_busy", rs1_busy_o, 1);
`endif
        next_cycle();
        @(negedge clk);
        check("haz_clear", rs1_busy_o, 0);
        next_cycle();

        // Same-cycle set/clear keeps the bit; a plain re-issue is a conflict
        issue_valid_i = 1; issue_rd_i = 4; rs1_i = 4;
        @(negedge clk);
        check("cf_none0", issue_conflict_o, 0);
        next_cycle();
        req1_valid_i = 1; req1_rd_i = 4; req1_data_i = 32'h44;
        @(negedge clk);
        check("cf_r1_ready", req1_ready_o, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("cf_none1", issue_conflict_o, 0);
        check("cf_set_wins", rs1_busy_o, 1);
        next_cycle();
        @(negedge clk);
        check("cf_still_busy", rs1_busy_o, 1);
        next_cycle();
        issue_valid_i = 1; issue_rd_i = 4;
        @(negedge clk);
        check("cf_none2", issue_conflict_o, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("cf_set", issue_conflict_o, 1);
        repeat (3) next_cycle();
        @(negedge clk);
        check("cf_sticky", issue_conflict_o, 1);
        next_cycle();

        // x0 destination
        req0_valid_i = 1; req0_rd_i = 0; req0_data_i = 32'h12345678;
        issue_valid_i = 1; issue_rd_i = 0; rs1_i = 0;
        @(negedge clk);
        check("x0_ready", req0_ready_o, 1);
        next_cycle();
        idle();
        @(negedge clk);
        check("x0_no_write", Reg_Write_o, 0);
        check("x0_rs_busy", rs1_busy_o, 0);
        next_cycle();

        // Reset mid-burst
        req0_valid_i = 1; req0_rd_i = 3; req0_data_i = 32'h33;
        issue_valid_i = 1; issue_rd_i = 12; rs1_i = 12; rs2_i = 3;
        next_cycle();
        issue_valid_i = 0; req0_data_i = 32'h34;
        @(negedge clk);
        check("mid_rs1_busy", rs1_busy_o, 1);
        check("mid_reg_write", Reg_Write_o, 1);
        #2 reset = 1'b0;
        #1;
        check("arst_reg_write", Reg_Write_o, 0);
        check("arst_write_reg", Write_Register_o, 0);
        check("arst_write_data", Write_Data_o, 0);
        check("arst_rs1_busy", rs1_busy_o, 0);
        check("arst_rs2_busy", rs2_busy_o, 0);
        check("arst_conflict", issue_conflict_o, 0);
        idle();
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_busy", rs1_busy_o, 0);
        next_cycle();

        // Mixed traffic; a requester not granted keeps its request stable
        hold0 = 0; hold1 = 0;
        for (int i = 0; i < 60; i++) begin
            if (!hold0) begin
                req0_valid_i = ($urandom_range(0, 2) != 0);
                req0_rd_i    = AW'($urandom_range(0, 7));
                req0_data_i  = $urandom;
            end
            if (!hold1) begin
                req1_valid_i = ($urandom_range(0, 1) != 0);
                req1_rd_i    = AW'($urandom_range(0, 7));
                req1_data_i  = $urandom;
            end
            issue_valid_i = ($urandom_range(0, 2) == 0);
            issue_rd_i    = AW'($urandom_range(0, 7));
            rs1_i         = AW'($urandom_range(0, 7));
            rs2_i         = AW'($urandom_range(0, 7));
            @(negedge clk);
            hold0 = req0_valid_i && !e_g0;
            hold1 = req1_valid_i && !e_g1;
            next_cycle();
        end
        idle();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
